// File: rtl/key_pkg.sv
// Shared definitions for the 8-key push-button emitter and decoder:
// key codes, active-low key patterns, FSM state constants and the code map.
package key_pkg;

  localparam logic [3:0] CODE_K0 = 4'b1110;
  localparam logic [3:0] CODE_K1 = 4'b1101;
  localparam logic [3:0] CODE_K2 = 4'b1100;
  localparam logic [3:0] CODE_K3 = 4'b1011;
  localparam logic [3:0] CODE_K4 = 4'b1010;
  localparam logic [3:0] CODE_K5 = 4'b1001;
  localparam logic [3:0] CODE_K6 = 4'b0111;
  localparam logic [3:0] CODE_K7 = 4'b0110;

  localparam logic [7:0] PAT_K0 = 8'b1111_1110;
  localparam logic [7:0] PAT_K1 = 8'b1111_1101;
  localparam logic [7:0] PAT_K2 = 8'b1111_1011;
  localparam logic [7:0] PAT_K3 = 8'b1111_0111;
  localparam logic [7:0] PAT_K4 = 8'b1110_1111;
  localparam logic [7:0] PAT_K5 = 8'b1101_1111;
  localparam logic [7:0] PAT_K6 = 8'b1011_1111;
  localparam logic [7:0] PAT_K7 = 8'b0111_1111;

  localparam logic [7:0] KEY_NONE = 8'hFF;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESS   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  typedef struct packed {
    logic       mapped;
    logic [7:0] pattern;
  } key_map_t;

  // Unmapped codes return KEY_NONE so a stray use never drives a key low.
  function automatic key_map_t key_map(input logic [3:0] code);
    key_map_t m;
    m.mapped  = 1'b1;
    m.pattern = KEY_NONE;
    case (code)
      CODE_K0: m.pattern = PAT_K0;
      CODE_K1: m.pattern = PAT_K1;
      CODE_K2: m.pattern = PAT_K2;
      CODE_K3: m.pattern = PAT_K3;
      CODE_K4: m.pattern = PAT_K4;
      CODE_K5: m.pattern = PAT_K5;
      CODE_K6: m.pattern = PAT_K6;
      CODE_K7: m.pattern = PAT_K7;
      default: m.mapped  = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/key_tick_div.sv
// DIV-cycle prescaler: tick_o is high in the last cycle of each period.
// Synchronous clear restarts the period at count zero.
module key_tick_div #(
  parameter int DIV = 2000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  output logic tick_o
);
  import key_pkg::*;

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] CNT_LAST = PW'(DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/key_press_gen.sv
// Accepts a key code over valid/ready and drives an active-low one-hot key bus,
// holding each press HOLD_TICKS ticks then releasing for GAP_TICKS ticks.
module key_press_gen #(
  parameter int DIV        = 2000,
  parameter int HOLD_TICKS = 8,
  parameter int GAP_TICKS  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       code_valid,
  input  logic [3:0] code,
  output logic       code_ready,
  output logic [7:0] key,
  output logic       busy,
  output logic       done,
  output logic       err
);
  import key_pkg::*;

  localparam int MAX_TICKS = (HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS;
  localparam int TW        = $clog2(MAX_TICKS + 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_TICKS - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_TICKS - 1);

  logic [1:0]    state_q, state_d;
  logic [7:0]    key_q, key_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          div_clr;
  logic          tick;
  key_map_t      km;

  key_tick_div #(
    .DIV(DIV)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .clr_i (div_clr),
    .tick_o(tick)
  );

  assign km = key_map(code);

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    tcnt_d  = tcnt_q;
    div_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Prescaler is held cleared so the first hold period starts exactly at the handshake.
        div_clr = 1'b1;
        tcnt_d  = '0;
        if (code_valid) begin
          if (km.mapped) begin
            state_d = ST_PRESS;
            key_d   = km.pattern;
            busy_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_PRESS: begin
        if (tick) begin
          if (tcnt_q == HOLD_LAST) begin
            state_d = ST_RELEASE;
            key_d   = KEY_NONE;
            tcnt_d  = '0;
            div_clr = 1'b1;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      ST_RELEASE: begin
        if (tick) begin
          if (tcnt_q == GAP_LAST) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            tcnt_d  = '0;
            div_clr = 1'b1;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        key_d   = KEY_NONE;
        busy_d  = 1'b0;
        tcnt_d  = '0;
        div_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      key_q   <= KEY_NONE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign code_ready = (state_q == ST_IDLE);
  assign key        = key_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_key_press_gen.sv
// Bench for key_press_gen: directed scenarios plus random offers, checked against a
// cycle-count timeline model of press/gap windows and a key-bus decoder model.
module tb_key_press_gen;

  localparam int DIV  = 4;
  localparam int HOLD = 3;
  localparam int GAP  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       code_valid = 1'b0;
  logic [3:0] code = 4'd0;
  logic       code_ready;
  logic [7:0] key;
  logic       busy, done, err;

  key_press_gen #(.DIV(DIV), .HOLD_TICKS(HOLD), .GAP_TICKS(GAP)) dut (
    .clk       (clk),
    .reset     (reset),
    .code_valid(code_valid),
    .code      (code),
    .code_ready(code_ready),
    .key       (key),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Key k (0..7) is driven by pulling bit k low.
  logic [3:0] ref_codes [8] = '{4'b1110, 4'b1101, 4'b1100, 4'b1011,
                                4'b1010, 4'b1001, 4'b0111, 4'b0110};

  int         cyc = 0;
  bit         m_idle = 1'b1;
  int         t_press_end = -1;
  int         t_end = -1;
  logic [7:0] exp_key = 8'hFF;
  logic       exp_done = 1'b0;
  logic       exp_err = 1'b0;
  logic [3:0] dec_code = 4'hF;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit ref_lookup(input logic [3:0] c, output logic [7:0] p);
    p = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      if (ref_codes[i] == c) begin
        p = ~(8'd1 << i);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // Timeline model: a press accepted at edge n holds until n+HOLD*DIV, idles at n+(HOLD+GAP)*DIV.
  task automatic model_edge();
    logic [7:0] p;
    cyc++;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (!reset) begin
      m_idle  = 1'b1;
      exp_key = 8'hFF;
    end else if (m_idle) begin
      if (code_valid) begin
        if (ref_lookup(code, p)) begin
          m_idle      = 1'b0;
          exp_key     = p;
          t_press_end = cyc + HOLD * DIV;
          t_end       = cyc + (HOLD + GAP) * DIV;
        end else begin
          exp_err = 1'b1;
        end
      end
    end else begin
      if (cyc == t_press_end) exp_key = 8'hFF;
      if (cyc == t_end) begin
        m_idle   = 1'b1;
        exp_done = 1'b1;
      end
    end
  endtask

  task automatic decoder_sample();
    for (int i = 0; i < 8; i++) begin
      if (key == ~(8'd1 << i)) dec_code = ref_codes[i];
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("key", {24'd0, key}, {24'd0, exp_key});
    chk("code_ready", {31'd0, code_ready}, {31'd0, m_idle});
    chk("busy", {31'd0, busy}, {31'd0, ~m_idle});
    chk("done", {31'd0, done}, {31'd0, exp_done});
    chk("err", {31'd0, err}, {31'd0, exp_err});
    decoder_sample();
  endtask

  task automatic offer_once(input logic [3:0] c);
    code       = c;
    code_valid = 1'b1;
    step();
    code_valid = 1'b0;
  endtask

  task automatic run_to_idle();
    int n = 0;
    while (!m_idle && n < 100) begin
      step();
      n++;
    end
    chk("idle_timeout", {31'd0, m_idle}, 32'd1);
  endtask

  initial begin
    int         n;
    int         press_cnt;
    int         rel_cnt;
    int         gap_cnt;
    bit         seen_first;
    bit         seen_second;
    logic [7:0] p;

    // Reset held, then released.
    for (int i = 0; i < 3; i++) step();
    reset = 1'b1;

    // Idle for 20 cycles.
    for (int i = 0; i < 20; i++) step();

    // Single press: count low and released cycles explicitly.
    offer_once(4'b1110);
    press_cnt = 1;
    rel_cnt   = 0;
    n         = 0;
    while (!done && n < 60) begin
      step();
      if (key == 8'b1111_1110) press_cnt++;
      if (key == 8'hFF && busy) rel_cnt++;
      n++;
    end
    chk("press_len", press_cnt, 32'd12);
    chk("release_len", rel_cnt, 32'd8);
    chk("done_ready", {31'd0, code_ready}, 32'd1);

    // Valid held high: second handshake lands right after the done cycle.
    code        = 4'b0110;
    code_valid  = 1'b1;
    gap_cnt     = 0;
    seen_first  = 1'b0;
    seen_second = 1'b0;
    n           = 0;
    while (!seen_second && n < 80) begin
      step();
      if (key == 8'b0111_1111) seen_first = 1'b1;
      if (seen_first && key == 8'hFF && busy) gap_cnt++;
      if (key == 8'b1111_0111) seen_second = 1'b1;
      if (exp_done) code = 4'b1011;
      n++;
    end
    code_valid = 1'b0;
    chk("b2b_second", {31'd0, seen_second}, 32'd1);
    chk("b2b_gap", gap_cnt, 32'd8);
    run_to_idle();

    // Unmapped code.
    offer_once(4'b0000);
    for (int i = 0; i < 5; i++) step();

    // Reset in the middle of a press.
    offer_once(4'b1100);
    for (int i = 0; i < 4; i++) step();
    reset = 1'b0;
    #1;
    chk("rst_key", {24'd0, key}, 32'h0000_00FF);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    m_idle  = 1'b1;
    exp_key = 8'hFF;
    for (int i = 0; i < 2; i++) step();
    reset = 1'b1;
    step();
    offer_once(4'b1101);
    run_to_idle();
    step();

    // Sweep mapped codes through the decoder model.
    for (int i = 0; i < 8; i++) begin
      dec_code = 4'hF;
      offer_once(ref_codes[i]);
      run_to_idle();
      chk("decode", {28'd0, dec_code}, {28'd0, ref_codes[i]});
    end

    // Random offers, including unmapped codes and valid while busy.
    for (int i = 0; i < 400; i++) begin
      code       = 4'($urandom_range(0, 15));
      code_valid = ($urandom_range(0, 3) == 0);
      step();
    end
    code_valid = 1'b0;
    run_to_idle();
    void'(ref_lookup(4'b0000, p));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
